// File: rtl/control_pasabajas.sv
// control_pasabajas: MAC schedule sequencer for the 5 kHz low-pass IIR datapath.
// Define AUTO_TRIG_EN for a free-running trigger every SAMPLE_DIV clocks.
module control_pasabajas #(
  parameter int SEL_W = 4,
  parameter int TERMS_W = 3,
  parameter int TERMS_Y = 3,
  parameter logic [SEL_W-1:0] SEL_IDLE = 4'hF
`ifdef AUTO_TRIG_EN
  , parameter int SAMPLE_DIV = 5000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  output logic             rst_acum,
  output logic             leer,
  output logic             desp,
  output logic             leer_y,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int T_MAX = (TERMS_W > TERMS_Y) ? TERMS_W : TERMS_Y;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(TERMS_W - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(TERMS_Y - 1);
  localparam logic [SEL_W-1:0] SEL_Y0 = SEL_W'(TERMS_W);

  typedef enum logic [2:0] {
    IDLE,
    MAC_W,
    STORE_W,
    MAC_Y,
    STORE_Y,
    SHIFT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             trig;

`ifdef AUTO_TRIG_EN
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap = (div == DIV_W'(SAMPLE_DIV - 1));
  assign trig = start | wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
    end else if (wrap) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end
`else
  assign trig = start;
`endif

  // Outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      sel      <= SEL_IDLE;
      rst_acum <= 1'b1;
      leer     <= 1'b0;
      desp     <= 1'b0;
      leer_y   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      leer   <= 1'b0;
      desp   <= 1'b0;
      leer_y <= 1'b0;
      done   <= 1'b0;
      if (trig && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (trig) begin
            state    <= MAC_W;
            count    <= '0;
            sel      <= '0;
            rst_acum <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC_W: begin
          if (count == LAST_W) begin
            state    <= STORE_W;
            count    <= '0;
            sel      <= SEL_IDLE;
            rst_acum <= 1'b1;
            leer     <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
            sel   <= SEL_W'(count) + SEL_W'(1);
          end
        end
        STORE_W: begin
          state    <= MAC_Y;
          count    <= '0;
          sel      <= SEL_Y0;
          rst_acum <= 1'b0;
        end
        MAC_Y: begin
          if (count == LAST_Y) begin
            state    <= STORE_Y;
            count    <= '0;
            sel      <= SEL_IDLE;
            rst_acum <= 1'b1;
            leer_y   <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
            sel   <= SEL_Y0 + SEL_W'(count) + SEL_W'(1);
          end
        end
        STORE_Y: begin
          state <= SHIFT;
          desp  <= 1'b1;
        end
        SHIFT: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          sel      <= SEL_IDLE;
          rst_acum <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
